// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic-light controller: one-hot phase codes,
// default phase lengths and widths, and the phase-time lookup helper.
package traffic_light_pkg;

    // One-hot phase-load codes; bit position doubles as the priority rank.
    typedef enum logic [2:0] {
        PHASE_NONE = 3'b000,
        GREEN      = 3'b001,
        YELLOW     = 3'b010,
        RED        = 3'b100
    } phase_code_e;

    localparam int NUM_PHASES       = 3;
    localparam int GREEN_BIT        = 0;
    localparam int YELLOW_BIT       = 1;
    localparam int RED_BIT          = 2;

    localparam int TIME_GREEN_LIGHT  = 15;
    localparam int TIME_YELLOW_LIGHT = 3;
    localparam int TIME_RED_LIGHT    = 18;

    localparam int CNT_WIDTH  = 5;
    localparam int INIT_WIDTH = 3;

    // Phase length selected by a bit of the init code.
    function automatic int time_for_bit(input int bit_idx, input int t_green,
                                        input int t_yellow, input int t_red);
        case (bit_idx)
            GREEN_BIT:  return t_green;
            YELLOW_BIT: return t_yellow;
            RED_BIT:    return t_red;
            default:    return 1;
        endcase
    endfunction

endpackage

// File: rtl/light_init_decode.sv
// Priority decoder from the phase-load code to a load strobe and the
// elaboration-time load value (phase length minus one, truncated).
module light_init_decode
    import traffic_light_pkg::*;
#(
    parameter int pTIME_GREEN_LIGHT  = TIME_GREEN_LIGHT,
    parameter int pTIME_YELLOW_LIGHT = TIME_YELLOW_LIGHT,
    parameter int pTIME_RED_LIGHT    = TIME_RED_LIGHT,
    parameter int pCNT_WIDTH         = CNT_WIDTH,
    parameter int pINIT_WIDTH        = INIT_WIDTH
) (
    input  logic [pINIT_WIDTH-1:0] init,
    output logic                   load_valid,
    output logic [pCNT_WIDTH-1:0]  load_value
);

    logic [pCNT_WIDTH-1:0] phase_load [NUM_PHASES];

    generate
        if (pINIT_WIDTH < NUM_PHASES) begin : g_bad_init_width
            $error("light_init_decode: pINIT_WIDTH must cover all phase bits");
        end

        for (genvar gi = 0; gi < NUM_PHASES; gi++) begin : g_load
            localparam int PHASE_T = time_for_bit(gi, pTIME_GREEN_LIGHT,
                                                  pTIME_YELLOW_LIGHT, pTIME_RED_LIGHT);
            if (PHASE_T < 1 || PHASE_T > (1 << pCNT_WIDTH)) begin : g_bad_time
                $error("light_init_decode: phase time out of range for counter width");
            end
            // T == 2^W truncates to all ones, which is still exactly T cycles.
            assign phase_load[gi] = pCNT_WIDTH'(PHASE_T - 1);
        end
    endgenerate

    // Ascending scan so the highest set bit (red) overrides lower ones.
    always_comb begin
        load_valid = 1'b0;
        load_value = '0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (init[i]) begin
                load_valid = 1'b1;
                load_value = phase_load[i];
            end
        end
    end

endmodule

// File: rtl/light_counter.sv
// Phase-duration down-counter: loads the selected phase length minus one,
// counts down to zero while enabled and flags phase end on last.
module light_counter
    import traffic_light_pkg::*;
#(
    parameter int pTIME_GREEN_LIGHT  = TIME_GREEN_LIGHT,
    parameter int pTIME_YELLOW_LIGHT = TIME_YELLOW_LIGHT,
    parameter int pTIME_RED_LIGHT    = TIME_RED_LIGHT,
    parameter int pCNT_WIDTH         = CNT_WIDTH,
    parameter int pINIT_WIDTH        = INIT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic [pINIT_WIDTH-1:0] init,
    output logic                   last,
    output logic [pCNT_WIDTH-1:0]  cnt_out
);

    logic                  load_valid;
    logic [pCNT_WIDTH-1:0] load_value;
    logic [pCNT_WIDTH-1:0] cnt_reg;
    logic [pCNT_WIDTH-1:0] cnt_next;
    logic                  cnt_zero;

    light_init_decode #(
        .pTIME_GREEN_LIGHT  (pTIME_GREEN_LIGHT),
        .pTIME_YELLOW_LIGHT (pTIME_YELLOW_LIGHT),
        .pTIME_RED_LIGHT    (pTIME_RED_LIGHT),
        .pCNT_WIDTH         (pCNT_WIDTH),
        .pINIT_WIDTH        (pINIT_WIDTH)
    ) u_init_decode (
        .init       (init),
        .load_valid (load_valid),
        .load_value (load_value)
    );

    assign cnt_zero = (cnt_reg == '0);

    // Load beats decrement regardless of en; the count saturates at zero.
    always_comb begin
        cnt_next = cnt_reg;
        if (load_valid) begin
            cnt_next = load_value;
        end else if (en && !cnt_zero) begin
            cnt_next = cnt_reg - pCNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign cnt_out = cnt_reg;
    assign last    = en & cnt_zero;

endmodule

// File: tb/tb_light_counter.sv
// Directed scenarios plus randomized load/enable/reset traffic for
// light_counter, checked against a cycle-level behavioural model.
module tb_light_counter;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic [2:0] init;
    logic       last;
    logic [4:0] cnt_out;

    int vectors;
    int miscompares;
    int rem;      // model: remaining count
    int edges;

    light_counter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .init    (init),
        .last    (last),
        .cnt_out (cnt_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    // Phase length in cycles for a load code, red > yellow > green.
    function automatic int phase_len(input logic [2:0] code);
        if (code[2]) return 18;
        if (code[1]) return 3;
        if (code[0]) return 15;
        return 0;
    endfunction

    // Called at a falling edge: drive inputs, check last, take one rising
    // edge through the model, then check the registered count.
    task automatic apply(input logic [2:0] i, input logic e);
        init = i;
        en   = e;
        #1;
        check("last_pre", int'(last), int'(e && rem == 0));
        @(posedge clk);
        if (i != 3'b000)
            rem = phase_len(i) - 1;
        else if (e && rem > 0)
            rem = rem - 1;
        @(negedge clk);
        check("cnt", int'(cnt_out), rem);
        check("last", int'(last), int'(e && rem == 0));
    endtask

    // Asynchronous reset pulse between edges.
    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        rem = 0;
        check("rst_cnt", int'(cnt_out), 0);
        check("rst_last", int'(last), int'(en));
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rem         = 0;
        rst_n       = 1'b0;
        en          = 1'b0;
        init        = 3'b000;

        // Reset state, then last follows en with no load.
        #12;
        check("reset_cnt", int'(cnt_out), 0);
        check("reset_last_en0", int'(last), 0);
        en = 1'b1;
        #1;
        check("reset_last_en1", int'(last), 1);
        @(negedge clk);
        rst_n = 1'b1;
        apply(3'b000, 1'b1);
        apply(3'b000, 1'b1);

        // Red phase: last after exactly 18 edges from the load edge.
        apply(3'b100, 1'b1);
        check("red_load", int'(cnt_out), 17);
        edges = 1;
        while (!last && edges < 64) begin
            apply(3'b000, 1'b1);
            edges++;
        end
        check("red_len", edges, 18);
        apply(3'b000, 1'b1);
        check("red_hold0", int'(cnt_out), 0);

        // Yellow then green, measuring phase lengths.
        apply(3'b010, 1'b1);
        check("yellow_drop_last", int'(last), 0);
        edges = 1;
        while (!last && edges < 64) begin
            apply(3'b000, 1'b1);
            edges++;
        end
        check("yellow_len", edges, 3);
        apply(3'b001, 1'b1);
        check("green_load", int'(cnt_out), 14);
        edges = 1;
        while (!last && edges < 64) begin
            apply(3'b000, 1'b1);
            edges++;
        end
        check("green_len", edges, 15);

        // Enable gating at 10.
        apply(3'b100, 1'b1);
        for (int k = 0; k < 7; k++) apply(3'b000, 1'b1);
        check("gate_at10", int'(cnt_out), 10);
        for (int k = 0; k < 5; k++) apply(3'b000, 1'b0);
        check("gate_hold", int'(cnt_out), 10);
        apply(3'b000, 1'b1);
        check("gate_resume", int'(cnt_out), 9);

        // Priority resolution and reload mid-count.
        apply(3'b111, 1'b1);
        check("prio_111", int'(cnt_out), 17);
        apply(3'b011, 1'b0);
        check("prio_011", int'(cnt_out), 2);
        apply(3'b100, 1'b1);
        for (int k = 0; k < 12; k++) apply(3'b000, 1'b1);
        check("reload_at5", int'(cnt_out), 5);
        apply(3'b001, 1'b1);
        check("reload_green", int'(cnt_out), 14);

        // Mid-count reset at 9.
        apply(3'b100, 1'b1);
        for (int k = 0; k < 8; k++) apply(3'b000, 1'b1);
        check("mid_at9", int'(cnt_out), 9);
        pulse_reset();
        for (int k = 0; k < 3; k++) apply(3'b000, 1'b1);
        check("mid_stay0", int'(cnt_out), 0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            logic [2:0] ri;
            logic       re;
            ri = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
            re = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 59) == 0) begin
                en = re;
                pulse_reset();
            end
            apply(ri, re);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
